// File: rtl/des_pkg.sv
// Shared constants, tables and the half-register rotator for the DES key schedule.
package des_pkg;
  localparam int HALF_W     = 28;
  localparam int CD_W       = 56;
  localparam int RK_W       = 48;
  localparam int NUM_ROUNDS = 16;
  localparam int IDX_W      = 4;

  typedef enum logic {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_e;

  // SHIFT_TBL[i] is the DES left-shift count for round i+1
  localparam logic [1:0] SHIFT_TBL [NUM_ROUNDS] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  // PC-2 source positions, DES 1-indexed
  localparam logic [5:0] PC2_TBL [RK_W] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32};

  // DES "left" rotation moves bit n+1 into bit n, i.e. toward index 0
  function automatic logic [HALF_W-1:0] rot_half(input logic [HALF_W-1:0] h,
                                                 input logic [1:0] amt,
                                                 input logic right);
    logic [HALF_W-1:0] r;
    r = h;
    case ({right, amt})
      3'b001:  r = {h[0], h[HALF_W-1:1]};
      3'b010:  r = {h[1:0], h[HALF_W-1:2]};
      3'b101:  r = {h[HALF_W-2:0], h[HALF_W-1]};
      3'b110:  r = {h[HALF_W-3:0], h[HALF_W-1:HALF_W-2]};
      default: r = h;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/des_key_schedule_if.sv
// Key-load / round-key handshake bundle between the PC-1 stage, scheduler and round datapath.
interface des_key_schedule_if;
  import des_pkg::*;

  logic             i_start;
  logic             i_decrypt;
  logic [CD_W-1:0]  i_cipherkey;
  logic             i_key_ready;
  logic             o_busy;
  logic             o_key_valid;
  logic [RK_W-1:0]  o_round_key;
  logic [IDX_W-1:0] o_round_idx;
  logic             o_done;

  modport master (
    output i_start, i_decrypt, i_cipherkey, i_key_ready,
    input  o_busy, o_key_valid, o_round_key, o_round_idx, o_done
  );

  modport slave (
    input  i_start, i_decrypt, i_cipherkey, i_key_ready,
    output o_busy, o_key_valid, o_round_key, o_round_idx, o_done
  );
endinterface

// File: rtl/des_pc2_compress.sv
// PC-2: pure 56->48 bit selection from the CD register.
module des_pc2_compress
  import des_pkg::*;
(
  input  logic [CD_W-1:0] cd_i,
  output logic [RK_W-1:0] key_o
);
  for (genvar n = 0; n < RK_W; n++) begin : g_sel
    assign key_o[n] = cd_i[PC2_TBL[n] - 6'd1];
  end
endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES round-key generator: one PC-2 round key per handshake, encrypt or decrypt order.
module des_key_schedule
  import des_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  des_key_schedule_if.slave  ks
);
  state_e           state_q;
  logic [CD_W-1:0]  cd_q, cd_load_d, cd_step_d;
  logic [IDX_W-1:0] cnt_q;
  logic             mode_q;
  logic             done_q;
  logic [1:0]       amt;
  logic [RK_W-1:0]  round_key;

  // Decrypt walks the encrypt shifts backwards, so step k uses SHIFT[17-k]
  always_comb begin
    amt       = mode_q ? SHIFT_TBL[4'd15 - cnt_q] : SHIFT_TBL[cnt_q + 4'd1];
    cd_step_d = {rot_half(cd_q[CD_W-1:HALF_W], amt, mode_q),
                 rot_half(cd_q[HALF_W-1:0],    amt, mode_q)};
    // CD16 equals CD0, so a decrypt load needs no rotation
    cd_load_d = ks.i_decrypt ? ks.i_cipherkey :
                {rot_half(ks.i_cipherkey[CD_W-1:HALF_W], 2'd1, 1'b0),
                 rot_half(ks.i_cipherkey[HALF_W-1:0],    2'd1, 1'b0)};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cd_q    <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ks.i_start) begin
            mode_q  <= ks.i_decrypt;
            cd_q    <= cd_load_d;
            cnt_q   <= '0;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (ks.i_key_ready) begin
            if (cnt_q == IDX_W'(NUM_ROUNDS - 1)) begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 4'd1;
              cd_q  <= cd_step_d;
            end
          end
        end
      endcase
    end
  end

  des_pc2_compress u_pc2 (
    .cd_i  (cd_q),
    .key_o (round_key)
  );

  assign ks.o_round_key = round_key;
  assign ks.o_busy      = (state_q == S_ISSUE);
  assign ks.o_key_valid = (state_q == S_ISSUE);
  assign ks.o_round_idx = cnt_q;
  assign ks.o_done      = done_q;
endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule using the classic 0x133457799BBCDFF1 key vectors.
module tb_des_key_schedule;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;

  des_key_schedule_if bus ();

  des_key_schedule dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .ks      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Published round keys K1..K16, DES bit 1 as the MSB of each constant
  localparam logic [47:0] KTAB [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
  // PC-1(0x133457799BBCDFF1) = C0 F0CCAAF, D0 556678F, bit 1 as MSB
  localparam logic [55:0] PC1_HEX = 56'hF0CCAAF556678F;

  typedef struct packed {
    logic [47:0] key;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  exp_t q[$];
  bit   exp_done_pending = 1'b0;

  function automatic logic [47:0] rev48(input logic [47:0] v);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[i] = v[47-i];
    return r;
  endfunction

  function automatic logic [55:0] rev56(input logic [55:0] v);
    logic [55:0] r;
    for (int i = 0; i < 56; i++) r[i] = v[55-i];
    return r;
  endfunction

  // sel 0 = classic key, 1 = all-ones, 2 = all-zeros
  function automatic logic [47:0] exp_key(input int sel, input bit dec, input int i);
    if (sel == 1) return '1;
    if (sel == 2) return '0;
    return rev48(KTAB[dec ? 15 - i : i]);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic push_exp(input int sel, input bit dec);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.key  = exp_key(sel, dec, i);
      e.idx  = 4'(i);
      e.last = (i == 15);
      q.push_back(e);
    end
  endtask

  // Monitor: pops one expectation per accepted key, checks the done pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_done_pending) begin
        chk("done_pulse", 64'(bus.o_done), 64'd1);
        exp_done_pending = 1'b0;
      end else if (bus.o_done) begin
        chk("unexpected_done", 64'(bus.o_done), 64'd0);
      end
      if (bus.o_key_valid && bus.i_key_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_key_idx", 64'(bus.o_round_idx), 64'hFFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("round_key", 64'(bus.o_round_key), 64'(e.key));
          chk("round_idx", 64'(bus.o_round_idx), 64'(e.idx));
          if (e.last) exp_done_pending = 1'b1;
        end
      end
    end
  end

  // Called at posedge+1 while the DUT is idle (or in its done cycle)
  task automatic issue_start(input logic [55:0] ck, input bit dec, output int s);
    bus.i_start = 1'b1; bus.i_decrypt = dec; bus.i_cipherkey = ck;
    @(posedge clk); #1;
    bus.i_start = 1'b0; bus.i_decrypt = ~dec; bus.i_cipherkey = ~ck;
    chk("first_valid", 64'(bus.o_key_valid), 64'd1);
    chk("first_busy", 64'(bus.o_busy), 64'd1);
    s = cyc;
  endtask

  task automatic follow(input int s0, input int sel, input bit dec,
                        input int stall_at, input int poke_at, input int rst_at,
                        input bit chain, input logic [55:0] ck2, input bit dec2, input int sel2);
    int  s = s0;
    int  cs = sel;
    bit  cd = dec;
    bit  ch = chain;
    bit  stalled = 1'b0;
    bit  poked = 1'b0;
    for (int c = 0; c < 120; c++) begin
      if (bus.o_done) begin
        chk("done_latency", 64'(cyc - s), 64'(stalled ? 19 : 16));
        chk("done_busy_low", 64'(bus.o_busy), 64'd0);
        chk("done_valid_low", 64'(bus.o_key_valid), 64'd0);
        if (!ch) return;
        ch = 1'b0; stalled = 1'b0; cs = sel2; cd = dec2;
        push_exp(sel2, dec2);
        issue_start(ck2, dec2, s);
        continue;
      end
      if (bus.o_key_valid && !stalled && int'(bus.o_round_idx) == stall_at) begin
        stalled = 1'b1;
        bus.i_key_ready = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          chk("stall_idx", 64'(bus.o_round_idx), 64'(stall_at));
          chk("stall_key", 64'(bus.o_round_key), 64'(exp_key(cs, cd, stall_at)));
        end
        bus.i_key_ready = 1'b1;
        continue;
      end
      if (bus.o_key_valid && !poked && int'(bus.o_round_idx) == poke_at) begin
        poked = 1'b1;
        bus.i_start = 1'b1; bus.i_decrypt = ~cd; bus.i_cipherkey = '1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        continue;
      end
      if (bus.o_key_valid && int'(bus.o_round_idx) == rst_at) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        q.delete();
        exp_done_pending = 1'b0;
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_valid", 64'(bus.o_key_valid), 64'd0);
        chk("rst_done", 64'(bus.o_done), 64'd0);
        chk("rst_idx", 64'(bus.o_round_idx), 64'd0);
        chk("rst_key", 64'(bus.o_round_key), 64'd0);
        rst_n = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    chk("schedule_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    logic [55:0] ck;
    int s;
    ck = rev56(PC1_HEX);
    rst_n = 1'b0;
    bus.i_start = 1'b0; bus.i_decrypt = 1'b0; bus.i_cipherkey = '0; bus.i_key_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(bus.o_busy), 64'd0);
    chk("reset_valid", 64'(bus.o_key_valid), 64'd0);
    chk("reset_done", 64'(bus.o_done), 64'd0);
    chk("reset_idx", 64'(bus.o_round_idx), 64'd0);
    chk("reset_key", 64'(bus.o_round_key), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // encrypt, then decrypt, then with backpressure at idx 5
    push_exp(0, 1'b0); issue_start(ck, 1'b0, s);
    follow(s, 0, 1'b0, -1, -1, -1, 1'b0, '0, 1'b0, 0);
    @(posedge clk); #1;
    push_exp(0, 1'b1); issue_start(ck, 1'b1, s);
    follow(s, 0, 1'b1, -1, -1, -1, 1'b0, '0, 1'b0, 0);
    @(posedge clk); #1;
    push_exp(0, 1'b0); issue_start(ck, 1'b0, s);
    follow(s, 0, 1'b0, 5, -1, -1, 1'b0, '0, 1'b0, 0);
    @(posedge clk); #1;

    // start pulse mid-schedule must be ignored
    push_exp(0, 1'b0); issue_start(ck, 1'b0, s);
    follow(s, 0, 1'b0, -1, 7, -1, 1'b0, '0, 1'b0, 0);
    @(posedge clk); #1;

    // reset at idx 9 aborts; idle window catches any stray done
    push_exp(0, 1'b1); issue_start(ck, 1'b1, s);
    follow(s, 0, 1'b1, -1, -1, 9, 1'b0, '0, 1'b0, 0);
    repeat (20) @(posedge clk);
    #1;
    push_exp(0, 1'b0); issue_start(ck, 1'b0, s);
    follow(s, 0, 1'b0, -1, -1, -1, 1'b0, '0, 1'b0, 0);
    @(posedge clk); #1;

    // all-ones then all-zeros started in the done cycle
    push_exp(1, 1'b0); issue_start('1, 1'b0, s);
    follow(s, 1, 1'b0, -1, -1, -1, 1'b1, '0, 1'b1, 2);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
